// File: rtl/chunked_seq_adder.sv
// chunked_seq_adder: multi-cycle adder/subtractor, CHUNK bits per clock with a registered inter-slice carry.
// Latency: operands accepted at edge k give out_valid after edge k+N (N = WIDTH/CHUNK); one result per N+2 cycles.
// Backpressure: in_ready is low from accept until the output handshake; the result is held while out_ready is low.
// Optional macro CHUNKED_ADDER_OVERFLOW_EN adds the o_ovf signed-overflow output.
module chunked_seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    output logic             o_ovf,
`endif
    output logic             o_cout
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum_o;
    logic             r_cout_o;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_ovf;
`endif

    logic [WIDTH-1:0] w_beff;
    logic [CHUNK:0]   w_slice;
    logic [WIDTH-1:0] w_sum_next;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;

    // Subtraction is folded into the operand: B is inverted at accept and the +1 comes in as carry-in.
    assign w_beff = i_sub ? ~i_b : i_b;

    // One slice add per cycle on the low CHUNK bits of the shifting operand registers.
    assign w_slice = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};

    // New slice enters at the top of the sum; after N cycles the first slice has reached bit 0.
    // The concatenate-then-shift form stays legal when CHUNK == WIDTH.
    assign w_sum_next = WIDTH'({w_slice[CHUNK-1:0], r_sum} >> CHUNK);
    assign w_a_next   = r_a >> CHUNK;
    assign w_b_next   = r_b >> CHUNK;

    // Control FSM plus datapath registers; outputs only change on the completing RUN cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sum_o     <= '0;
            r_cout_o    <= 1'b0;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_a        <= i_a;
                        r_b        <= w_beff;
                        r_carry    <= i_sub | i_cin;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
                        r_a_msb    <= i_a[WIDTH-1];
                        r_b_msb    <= w_beff[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    r_a     <= w_a_next;
                    r_b     <= w_b_next;
                    r_carry <= w_slice[CHUNK];
                    r_sum   <= w_sum_next;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_sum_o     <= w_sum_next;
                        r_cout_o    <= w_slice[CHUNK];
`ifdef CHUNKED_ADDER_OVERFLOW_EN
                        r_ovf       <= (r_a_msb == r_b_msb) && (w_sum_next[WIDTH-1] != r_a_msb);
`endif
                    end
                end
                S_DONE: begin
                    // A simultaneous in_valid is not taken here; the IDLE bubble accepts it next cycle.
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_sum       = r_sum_o;
    assign o_cout      = r_cout_o;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    assign o_ovf       = r_ovf;
`endif

endmodule
